// File: rtl/sweep_counter_pkg.sv
// Purpose: shared defaults and FSM state encoding for the sweep counter slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sweep_counter_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/up_down_count_core.sv
// Purpose: loadable up/down counter stepped by the sweep FSM.
// Latency: load or step visible one cycle after the controlling edge.
// Backpressure: none; holds value whenever load and en are both low.
//
// Ports: clk, rst (async active-low), load/load_val (synchronous load,
//        wins over en), en (step enable), mode (0 = +1, 1 = -1), count.
module up_down_count_core
  import sweep_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic             mode,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= mode ? (count - ONE) : (count + ONE);
    end
  end

endmodule

// File: rtl/sweep_counter_ctrl.sv
// Purpose: triangle sweep lo->hi->lo repeated 'sweeps' times, with abort.
// Latency: count=lo one cycle after accepted start; done pulses one cycle after final lo.
// Backpressure: start ignored while busy; rejected start answered by a one-cycle err.
//
// Ports: clk, rst (async active-low), start/abort (requests), lo/hi/sweeps
//        (limits, latched on accepted start), count/mode (counter value and
//        direction), busy (UP/DOWN), done (normal completion), err (bad start).
module sweep_counter_ctrl
  import sweep_counter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  input  logic [WIDTH-1:0] sweeps,
  output logic [WIDTH-1:0] count,
  output logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] lo_q, hi_q, rem_q;
  logic             mode_q, err_q;
  logic             core_load, core_en, core_mode;
  logic             accept, reject, rem_dec;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The turn at either limit is itself a counter step in the opposite
  // direction (hi -> hi-1, lo -> lo+1), so the counter never steps past a
  // limit and cannot wrap even with lo=0 or hi=all-ones.
  always_comb begin
    state_d   = state_q;
    core_load = 1'b0;
    core_en   = 1'b0;
    core_mode = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    rem_dec   = 1'b0;
    case (state_q)
      IDLE: begin
        // abort is deliberately not looked at here: start wins.
        if (start) begin
          if ((lo < hi) && (sweeps != '0)) begin
            accept    = 1'b1;
            core_load = 1'b1;
            state_d   = UP;
          end else begin
            reject = 1'b1;
          end
        end
      end
      UP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (count == hi_q) begin
          core_en   = 1'b1;
          core_mode = 1'b1;
          state_d   = DOWN;
        end else begin
          core_en = 1'b1;
        end
      end
      DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (count != lo_q) begin
          core_en   = 1'b1;
          core_mode = 1'b1;
        end else if (rem_q > ONE) begin
          rem_dec = 1'b1;
          core_en = 1'b1;
          state_d = UP;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lo_q   <= '0;
      hi_q   <= '0;
      rem_q  <= '0;
      mode_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= reject;
      if (accept) begin
        lo_q   <= lo;
        hi_q   <= hi;
        rem_q  <= sweeps;
        mode_q <= 1'b0;
      end else begin
        if (rem_dec) rem_q <= rem_q - ONE;
        // Direction output follows the last step actually taken.
        if (core_en) mode_q <= core_mode;
      end
    end
  end

  up_down_count_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk      (clk),
    .rst      (rst),
    .load     (core_load),
    .load_val (lo),
    .en       (core_en),
    .mode     (core_mode),
    .count    (count)
  );

  assign mode = mode_q;
  assign busy = (state_q == UP) || (state_q == DOWN);
  assign done = (state_q == DONE);
  assign err  = err_q;

endmodule

// File: tb/tb_sweep_counter_ctrl.sv
module tb_sweep_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] lo = '0;
  logic [3:0] hi = '0;
  logic [3:0] sweeps = '0;
  logic [3:0] count;
  logic       mode, busy, done, err;
  logic [6:0] obs;

  int checks = 0;
  int errors = 0;

  assign obs = {count, busy, done, err};

  sweep_counter_ctrl #(.WIDTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .lo     (lo),
    .hi     (hi),
    .sweeps (sweeps),
    .count  (count),
    .mode   (mode),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({obs, mode} !== 8'b0) begin
      errors++;
      $display("FAIL reset_async: got {count,busy,done,err,mode}=%b expected 00000000", {obs, mode});
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({obs, mode} !== 8'b0) begin
      errors++;
      $display("FAIL reset_release_idle: got %b expected 00000000", {obs, mode});
    end
  endtask

  task automatic test_single_sweep();
    logic [3:0] exp_c [7] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd4, 4'd3, 4'd2};
    logic       exp_m [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    lo = 4'd2; hi = 4'd5; sweeps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    // Input limits changed mid-sweep must not matter.
    lo = 4'd0; hi = 4'd15; sweeps = 4'd0;
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (obs !== {exp_c[i], 3'b100}) begin
        errors++;
        $display("FAIL single_sweep[%0d]: got {count,busy,done,err}=%b expected %b", i, obs, {exp_c[i], 3'b100});
      end
      checks++;
      if (mode !== exp_m[i]) begin
        errors++;
        $display("FAIL single_sweep_mode[%0d]: got %b expected %b", i, mode, exp_m[i]);
      end
      step();
    end
    checks++;
    if (obs !== {4'd2, 3'b010}) begin
      errors++;
      $display("FAIL single_sweep_done: got %b expected %b", obs, {4'd2, 3'b010});
    end
    step();
    checks++;
    if (obs !== {4'd2, 3'b000}) begin
      errors++;
      $display("FAIL single_sweep_idle: got %b expected %b", obs, {4'd2, 3'b000});
    end
  endtask

  task automatic test_full_range();
    int         peaks = 0;
    int         p;
    logic [3:0] ec;
    logic       em;
    lo = 4'd0; hi = 4'd15; sweeps = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i <= 60; i++) begin
      p  = i % 30;
      ec = (p <= 15) ? 4'(p) : 4'(30 - p);
      em = (i != 0) && ((p == 0) || (p > 15));
      checks++;
      if ({obs, mode} !== {ec, 3'b100, em}) begin
        errors++;
        $display("FAIL full_range[%0d]: got {count,busy,done,err,mode}=%b expected %b", i, {obs, mode}, {ec, 3'b100, em});
      end
      if (count == 4'd15) peaks++;
      step();
    end
    checks++;
    if (peaks != 2) begin
      errors++;
      $display("FAIL full_range_peaks: got %0d expected 2", peaks);
    end
    checks++;
    if (obs !== {4'd0, 3'b010}) begin
      errors++;
      $display("FAIL full_range_done: got %b expected %b", obs, {4'd0, 3'b010});
    end
    step();
    checks++;
    if (obs !== {4'd0, 3'b000}) begin
      errors++;
      $display("FAIL full_range_idle: got %b expected %b", obs, {4'd0, 3'b000});
    end
  endtask

  task automatic test_reject();
    logic [3:0] vlo [3] = '{4'd7, 4'd1, 4'd9};
    logic [3:0] vhi [3] = '{4'd7, 4'd3, 4'd3};
    logic [3:0] vsw [3] = '{4'd1, 4'd0, 4'd2};
    for (int i = 0; i < 3; i++) begin
      lo = vlo[i]; hi = vhi[i]; sweeps = vsw[i]; start = 1'b1;
      step();
      start = 1'b0;
      checks++;
      if (obs !== {4'd0, 3'b001}) begin
        errors++;
        $display("FAIL reject_err[%0d]: got %b expected %b", i, obs, {4'd0, 3'b001});
      end
      step();
      checks++;
      if (obs !== {4'd0, 3'b000}) begin
        errors++;
        $display("FAIL reject_after[%0d]: got %b expected %b", i, obs, {4'd0, 3'b000});
      end
    end
  endtask

  task automatic test_abort_ignore();
    lo = 4'd1; hi = 4'd9; sweeps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if (obs !== {4'd1, 3'b100}) begin
      errors++;
      $display("FAIL abort_first: got %b expected %b", obs, {4'd1, 3'b100});
    end
    step();
    lo = 4'd0; hi = 4'd15; sweeps = 4'd3; start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({obs, mode} !== {4'd3, 3'b100, 1'b0}) begin
      errors++;
      $display("FAIL ignored_start: got %b expected %b", {obs, mode}, {4'd3, 3'b100, 1'b0});
    end
    step();
    checks++;
    if (obs !== {4'd4, 3'b100}) begin
      errors++;
      $display("FAIL abort_at4: got %b expected %b", obs, {4'd4, 3'b100});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs !== {4'd4, 3'b000}) begin
      errors++;
      $display("FAIL abort_idle: got %b expected %b", obs, {4'd4, 3'b000});
    end
    step();
    checks++;
    if (obs !== {4'd4, 3'b000}) begin
      errors++;
      $display("FAIL abort_no_done: got %b expected %b", obs, {4'd4, 3'b000});
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if (obs !== {4'd4, 3'b000}) begin
      errors++;
      $display("FAIL abort_in_idle: got %b expected %b", obs, {4'd4, 3'b000});
    end
  endtask

  task automatic test_start_abort_same();
    logic [3:0] exp_c [3] = '{4'd3, 4'd4, 4'd3};
    lo = 4'd3; hi = 4'd4; sweeps = 4'd1; start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (obs !== {exp_c[i], 3'b100}) begin
        errors++;
        $display("FAIL start_abort[%0d]: got %b expected %b", i, obs, {exp_c[i], 3'b100});
      end
      step();
    end
    checks++;
    if (obs !== {4'd3, 3'b010}) begin
      errors++;
      $display("FAIL start_abort_done: got %b expected %b", obs, {4'd3, 3'b010});
    end
  endtask

  task automatic test_async_reset();
    logic [3:0] exp_c [5] = '{4'd1, 4'd2, 4'd3, 4'd2, 4'd1};
    step();
    lo = 4'd2; hi = 4'd8; sweeps = 4'd2; start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    checks++;
    if (obs !== {4'd6, 3'b100}) begin
      errors++;
      $display("FAIL pre_reset: got %b expected %b", obs, {4'd6, 3'b100});
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({obs, mode} !== 8'b0) begin
      errors++;
      $display("FAIL mid_reset: got %b expected 00000000", {obs, mode});
    end
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({obs, mode} !== 8'b0) begin
      errors++;
      $display("FAIL no_resume: got %b expected 00000000", {obs, mode});
    end
    lo = 4'd1; hi = 4'd3; sweeps = 4'd1; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== {exp_c[i], 3'b100}) begin
        errors++;
        $display("FAIL post_reset_sweep[%0d]: got %b expected %b", i, obs, {exp_c[i], 3'b100});
      end
      step();
    end
    checks++;
    if (obs !== {4'd1, 3'b010}) begin
      errors++;
      $display("FAIL post_reset_done: got %b expected %b", obs, {4'd1, 3'b010});
    end
  endtask

  initial begin
    test_reset();
    test_single_sweep();
    test_full_range();
    test_reject();
    test_abort_ignore();
    test_start_abort_same();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sweep_counter_ctrl.md
SWEEP_COUNTER_CTRL -- requirements
Module: sweep_counter_ctrl

Interface
REQ-001 Parameter: WIDTH, 4, bit width of count, lo, hi and sweeps.
REQ-002 Port: clk  in  1  single clock; all state on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: start  in  1  sweep request, sampled in IDLE only.
REQ-005 Port: abort  in  1  terminates an active sweep.
REQ-006 Port: lo  in  WIDTH  lower turn-around limit, latched on accepted start.
REQ-007 Port: hi  in  WIDTH  upper turn-around limit, latched on accepted start.
REQ-008 Port: sweeps  in  WIDTH  number of full lo->hi->lo cycles, latched on accepted start.
REQ-009 Port: count  out  WIDTH  current counter value.
REQ-010 Port: mode  out  1  counting direction: 0 = up, 1 = down.
REQ-011 Port: busy  out  1  high in UP and DOWN states.
REQ-012 Port: done  out  1  one-cycle pulse on normal completion.
REQ-013 Port: err  out  1  one-cycle pulse on rejected start.

Function
REQ-014 FSM states SHALL be IDLE, UP, DOWN, DONE.
REQ-015 IDLE: start=1 with lo<hi and sweeps!=0 SHALL latch lo/hi/sweeps, load count=lo and enter UP on the same edge; busy=1 from the next cycle.
REQ-016 IDLE: start=1 with lo>=hi or sweeps==0 SHALL pulse err for one cycle, remain IDLE, leave count unchanged.
REQ-017 UP: count!=hi -> count+1, mode=0; count==hi -> count=hi-1, mode=1, enter DOWN.
REQ-018 DOWN: count!=lo -> count-1, mode=1; count==lo and remaining sweeps>1 -> decrement remaining, count=lo+1, mode=0, enter UP.
REQ-019 DOWN: count==lo and remaining sweeps==1 -> enter DONE, count holds lo.
REQ-020 DONE: done=1 and busy=0 for exactly one cycle, then IDLE; count holds.
REQ-021 Counter SHALL never wrap: the turn at hi and lo precedes any overflow; hi=2^WIDTH-1 and lo=0 are legal.
REQ-022 start while busy SHALL be ignored; latched limits SHALL not change mid-sweep.
REQ-023 abort in UP/DOWN SHALL enter IDLE on the next edge, count holds, busy=0, no done pulse.
REQ-024 abort in IDLE or DONE SHALL have no effect; simultaneous start and abort in IDLE SHALL accept start.
REQ-025 One sweep SHALL take 2*(hi-lo) cycles from the first count=lo to the return to count=lo.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE, count=0, mode=0, busy=0, done=0, err=0, remaining sweeps=0.
REQ-027 rst asserted mid-sweep SHALL abandon the sweep without a done pulse; operation resumes only on a new start after rst=1.

Structure
REQ-028 Package sweep_counter_pkg SHALL hold the WIDTH default and the FSM state enum.
REQ-029 Counting SHALL be done in sub-module up_down_count_core (inputs: load, load_val, en, mode; output: count); the FSM drives it.

Verification
REQ-030 lo=2, hi=5, sweeps=1, start pulse -> count 2,3,4,5,4,3,2 on consecutive cycles, mode toggles at 5, done pulse after the final 2, busy low after.
REQ-031 lo=0, hi=15, sweeps=2 -> count reaches 15 twice with no wrap to 0 and returns to 0 twice; one done pulse after 60 cycles.
REQ-032 lo=7, hi=7, start -> err pulses for one cycle, busy stays 0, count unchanged; repeated with sweeps=0.
REQ-033 abort at count=4 during UP (lo=1, hi=9) -> IDLE next cycle, count holds 4, no done; a second start during the sweep has no effect.
REQ-034 rst=0 pulse at count=6 mid-sweep -> count=0 immediately, all outputs 0; a new start after release runs normally.
